// File: rtl/threefish_subkey_rev_gen.sv
// Threefish-512 reverse-order subkey generator for the decryption path.
// A 9-word key ring and a 3-word tweak ring are rotated back one position per
// accepted subkey, so subkeys LAST_IDX down to 0 come out one per handshake.
module threefish_subkey_rev_gen #(
   parameter logic [63:0] KEY_PARITY = 64'h1BD11BDAA9FC1A22,
   parameter int          LAST_IDX   = 18
) (
   input  logic         inClk,
   input  logic         inRst,
   input  logic [511:0] inKey,
   input  logic [127:0] inTweak,
   input  logic         inLoad,
   input  logic         inNext,
   output logic [511:0] outSubKey,
   output logic [4:0]   outSubKeyIdx,
   output logic         outValid,
   output logic         outBusy,
   output logic         outDone
);

   localparam logic [4:0] LAST5 = 5'(LAST_IDX);

   typedef enum logic [1:0] {IDLE, PREP, EMIT} state_t;

   state_t state, state_nxt;

   logic [511:0]      key_q;
   logic [127:0]      tweak_q;
   logic [8:0][63:0]  ring_q, ring_init, ring_rot, ext_key;
   logic [2:0][63:0]  tring_q, tring_init, tring_rot, ext_tweak;

   logic cap, ring_ld, fill, step, fin;

   // Subkey from the current ring alignment: words 0..4 plain, 5/6 add tweak, 7 adds s.
   function automatic logic [511:0] subkey_f(input logic [8:0][63:0] r,
                                             input logic [2:0][63:0] t,
                                             input logic [4:0]       s);
      subkey_f = {r[0], r[1], r[2], r[3], r[4],
                  r[5] + t[0], r[6] + t[1], r[7] + {59'd0, s}};
   endfunction

   // Extended key/tweak words derived from the captured inputs.
   for (genvar i = 0; i < 8; i++) begin : g_kw
      assign ext_key[i] = key_q[511-64*i -: 64];
   end
   assign ext_key[8]   = KEY_PARITY ^ ext_key[0] ^ ext_key[1] ^ ext_key[2] ^ ext_key[3]
                                    ^ ext_key[4] ^ ext_key[5] ^ ext_key[6] ^ ext_key[7];
   assign ext_tweak[0] = tweak_q[127:64];
   assign ext_tweak[1] = tweak_q[63:0];
   assign ext_tweak[2] = tweak_q[127:64] ^ tweak_q[63:0];

   // Initial alignment for LAST_IDX and the one-step-back rotation.
   for (genvar p = 0; p < 9; p++) begin : g_kr
      assign ring_init[p] = ext_key[(LAST_IDX + p) % 9];
      assign ring_rot[p]  = ring_q[(p + 8) % 9];
   end
   for (genvar q = 0; q < 3; q++) begin : g_tr
      assign tring_init[q] = ext_tweak[(LAST_IDX + q) % 3];
      assign tring_rot[q]  = tring_q[(q + 2) % 3];
   end

   assign outBusy = (state != IDLE);

   // State register.
   always_ff @(posedge inClk or posedge inRst) begin
      if (inRst) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and per-cycle datapath strobes.
   always_comb begin
      state_nxt = state;
      cap       = 1'b0;
      ring_ld   = 1'b0;
      fill      = 1'b0;
      step      = 1'b0;
      fin       = 1'b0;
      case (state)
         IDLE: begin
            if (inLoad) begin
               cap       = 1'b1;
               state_nxt = PREP;
            end
         end
         PREP: begin
            ring_ld   = 1'b1;
            state_nxt = EMIT;
         end
         EMIT: begin
            if (!outValid) begin
               fill = 1'b1;
            end else if (inNext) begin
               if (outSubKeyIdx != 5'd0) begin
                  step = 1'b1;
               end else begin
                  fin       = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Key/tweak capture, ring rotation and registered subkey outputs.
   always_ff @(posedge inClk or posedge inRst) begin
      if (inRst) begin
         key_q        <= '0;
         tweak_q      <= '0;
         ring_q       <= '0;
         tring_q      <= '0;
         outSubKey    <= '0;
         outSubKeyIdx <= '0;
         outValid     <= 1'b0;
         outDone      <= 1'b0;
      end else begin
         outDone <= fin;
         if (cap) begin
            key_q   <= inKey;
            tweak_q <= inTweak;
         end
         if (ring_ld) begin
            ring_q  <= ring_init;
            tring_q <= tring_init;
         end
         if (fill) begin
            outSubKey    <= subkey_f(ring_q, tring_q, LAST5);
            outSubKeyIdx <= LAST5;
            outValid     <= 1'b1;
         end
         if (step) begin
            ring_q       <= ring_rot;
            tring_q      <= tring_rot;
            outSubKey    <= subkey_f(ring_rot, tring_rot, outSubKeyIdx - 5'd1);
            outSubKeyIdx <= outSubKeyIdx - 5'd1;
         end
         if (fin) outValid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_threefish_subkey_rev_gen.sv
// Bench for threefish_subkey_rev_gen: key-schedule reference model plus
// directed sequences (zero key, small tweak, random, backpressure, ignored
// load, mid-sequence reset).
module tb_threefish_subkey_rev_gen;

   localparam logic [63:0] PAR = 64'h1BD11BDAA9FC1A22;

   logic         clk = 1'b0;
   logic         rst;
   logic [511:0] inKey;
   logic [127:0] inTweak;
   logic         inLoad, inNext;
   logic [511:0] outSubKey;
   logic [4:0]   outSubKeyIdx;
   logic         outValid, outBusy, outDone;

   int n_checks = 0;
   int n_fail   = 0;

   bit           mon_en = 0;
   logic [4:0]   exp_idx;
   logic [511:0] cur_key;
   logic [127:0] cur_tw;
   logic [511:0] seen [19];

   threefish_subkey_rev_gen #(.KEY_PARITY(PAR), .LAST_IDX(18)) dut (
      .inClk(clk), .inRst(rst), .inKey(inKey), .inTweak(inTweak),
      .inLoad(inLoad), .inNext(inNext), .outSubKey(outSubKey),
      .outSubKeyIdx(outSubKeyIdx), .outValid(outValid), .outBusy(outBusy),
      .outDone(outDone)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Encryption key schedule for subkey s (as for inSubKeyId4 = 4*s).
   function automatic logic [511:0] ref_sk(input logic [511:0] key, input logic [127:0] tw, input int s);
      logic [63:0] k [9];
      logic [63:0] t [3];
      logic [63:0] w;
      logic [511:0] r;
      k[8] = PAR;
      for (int i = 0; i < 8; i++) begin
         k[i] = key[511-64*i -: 64];
         k[8] ^= k[i];
      end
      t[0] = tw[127:64];
      t[1] = tw[63:0];
      t[2] = t[0] ^ t[1];
      r = '0;
      for (int i = 0; i < 8; i++) begin
         w = k[(s + i) % 9];
         if (i == 5) w += t[s % 3];
         if (i == 6) w += t[(s + 1) % 3];
         if (i == 7) w += 64'(s);
         r[511-64*i -: 64] = w;
      end
      return r;
   endfunction

   // Compare every valid subkey against the model.
   always @(negedge clk) begin
      if (mon_en && outValid) begin
         chk("mon_idx", 512'(outSubKeyIdx), 512'(exp_idx));
         chk("mon_subkey", outSubKey, ref_sk(cur_key, cur_tw, int'(exp_idx)));
         if (outSubKeyIdx < 5'd19) seen[outSubKeyIdx] = outSubKey;
      end
   end

   // Track which index must come next after each accepted handshake.
   always @(posedge clk) begin
      if (mon_en && !rst && outValid && inNext && exp_idx != 5'd0)
         exp_idx = exp_idx - 5'd1;
   end

   task automatic do_load(input logic [511:0] key, input logic [127:0] tw);
      @(posedge clk); #1;
      for (int i = 0; i < 19; i++) seen[i] = 'x;
      inKey = key; inTweak = tw; cur_key = key; cur_tw = tw;
      exp_idx = 5'd18; mon_en = 1; inLoad = 1;
      @(posedge clk); #1;
      inLoad = 0; inKey = ~key; inTweak = ~tw;
      chk("lat_busy_n", 512'(outBusy), 512'd1);
      chk("lat_valid_n", 512'(outValid), 512'd0);
      @(posedge clk); #1;
      chk("lat_valid_n1", 512'(outValid), 512'd0);
      @(posedge clk); #1;
      chk("lat_valid_n2", 512'(outValid), 512'd1);
      chk("lat_idx_n2", 512'(outSubKeyIdx), 512'd18);
   endtask

   task automatic drain(output int nvalid);
      bit done_seen;
      nvalid = 0; done_seen = 0;
      for (int c = 0; c < 80 && !done_seen; c++) begin
         @(negedge clk);
         if (outValid) nvalid++;
         if (outDone) begin
            done_seen = 1;
            chk("done_busy", 512'(outBusy), 512'd0);
            chk("done_valid", 512'(outValid), 512'd0);
         end
      end
      chk("done_seen", 512'(done_seen), 512'd1);
      if (done_seen) begin
         @(negedge clk);
         chk("done_pulse", 512'(outDone), 512'd0);
      end
   endtask

   task automatic wait_idx(input logic [4:0] target);
      bit ok;
      ok = 0;
      for (int c = 0; c < 40 && !ok; c++) begin
         @(negedge clk);
         if (outValid && outSubKeyIdx == target) ok = 1;
      end
      chk("wait_idx", 512'(ok), 512'd1);
   endtask

   initial begin
      int n;
      logic [511:0] rk, sk_hold;
      logic [127:0] rt;
      rst = 1; inKey = '0; inTweak = '0; inLoad = 0; inNext = 0;
      #1;
      chk("rst_outs", {outSubKey, 5'(outSubKeyIdx), outValid, outBusy, outDone}, '0);
      repeat (2) @(posedge clk);
      #1 rst = 0;

      // Zero key and tweak, inNext held high.
      inNext = 1;
      do_load('0, '0);
      drain(n);
      chk("zero_nvalid", 512'(n), 512'd19);
      chk("zero_s18", seen[18], 512'h12);
      chk("zero_s17", seen[17], {PAR, 384'd0, 64'h11});
      chk("zero_s1", seen[1], {448'd0, 64'h1BD11BDAA9FC1A23});
      chk("zero_s0", seen[0], 512'd0);

      // Small tweak: rotation of the tweak ring.
      do_load('0, {64'd1, 64'd2});
      drain(n);
      chk("tw_s18", seen[18], {320'd0, 64'd1, 64'd2, 64'h12});
      chk("tw_s17", seen[17], {PAR, 256'd0, 64'd3, 64'd1, 64'h11});
      chk("tw_s16", seen[16], {64'd0, PAR, 192'd0, 64'd2, 64'd3, 64'h10});

      // Random key and tweak, full sequence against the model.
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 16; i++) rk[32*i +: 32] = $urandom;
         for (int i = 0; i < 4; i++) rt[32*i +: 32] = $urandom;
         do_load(rk, rt);
         drain(n);
         chk("rand_nvalid", 512'(n), 512'd19);
      end

      // Backpressure at s = 10.
      for (int i = 0; i < 16; i++) rk[32*i +: 32] = $urandom;
      do_load(rk, 128'h0123456789ABCDEF_FEDCBA9876543210);
      wait_idx(5'd10);
      #1 inNext = 0;
      sk_hold = outSubKey;
      repeat (5) begin
         @(negedge clk);
         chk("bp_idx", 512'(outSubKeyIdx), 512'd10);
         chk("bp_key", outSubKey, sk_hold);
         chk("bp_valid", 512'(outValid), 512'd1);
      end
      #1 inNext = 1;
      drain(n);
      chk("bp_rest", 512'(n), 512'd10);

      // inLoad with another key during EMIT is ignored.
      do_load(rk, 128'h55);
      wait_idx(5'd12);
      #1 inKey = ~rk; inTweak = 128'hAA; inLoad = 1;
      @(posedge clk); #1 inLoad = 0;
      drain(n);
      chk("ign_rest", 512'(n), 512'd12);
      chk("ign_idle", 512'(outBusy), 512'd0);

      // Reset mid-sequence at s = 7.
      do_load(rk, 128'h77);
      wait_idx(5'd7);
      #1 rst = 1; mon_en = 0;
      #1 chk("mid_rst_outs", {outSubKey, 5'(outSubKeyIdx), outValid, outBusy, outDone}, '0);
      @(posedge clk); #1 rst = 0;
      repeat (3) begin
         @(negedge clk);
         chk("mid_rst_nodone", 512'({outDone, outBusy}), 512'd0);
      end
      do_load(~rk, 128'h99);
      drain(n);
      chk("restart_nvalid", 512'(n), 512'd19);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
